// File: rtl/cv32e40p_load_resp_unit_pkg.sv
// Shared types and helpers for the load-response unit.
//   lsu_size_e    : access size encoding carried on push_type_i
//   load_desc_t   : per-transaction descriptor held in the outstanding queue
//   crosses_word  : does an access of this size/offset spill into the next word
//   extend_load   : sign/zero extension of aligned load data
package cv32e40p_load_resp_unit_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_size_e;

    typedef struct packed {
        logic [1:0] size;      // lsu_size_e encoding; 2'b11 behaves as word
        logic       sign_ext;
        logic [1:0] offset;
        logic       split;     // second beat of a misaligned access
        logic       we;
        logic [5:0] waddr;
    } load_desc_t;

    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] offset);
        logic res;
        case (size)
            LSU_HALF: res = (offset == 2'd3);
            LSU_BYTE: res = 1'b0;
            default:  res = (offset != 2'd0);
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic        sign_ext);
        logic [31:0] res;
        case (size)
            LSU_BYTE: res = {{24{sign_ext & data[7]}}, data[7:0]};
            LSU_HALF: res = {{16{sign_ext & data[15]}}, data[15:0]};
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_load_resp_unit_if.sv
// Bus-side signals of the load-response unit.
//   push_*        : descriptor of a data-bus request granted this cycle
//   full_o/empty_o: outstanding-queue status
//   data_*        : OBI response channel (rvalid, rdata, err)
// master = LSU/bus side driving requests and responses, slave = the unit.
interface cv32e40p_load_resp_unit_if;

    logic        push_i;
    logic [1:0]  push_type_i;
    logic        push_sign_ext_i;
    logic [1:0]  push_offset_i;
    logic        push_split_i;
    logic        push_we_i;
    logic [5:0]  push_waddr_i;
    logic        full_o;
    logic        empty_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    modport master (
        output push_i, push_type_i, push_sign_ext_i, push_offset_i, push_split_i,
               push_we_i, push_waddr_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  full_o, empty_o
    );

    modport slave (
        input  push_i, push_type_i, push_sign_ext_i, push_offset_i, push_split_i,
               push_we_i, push_waddr_i, data_rvalid_i, data_rdata_i, data_err_i,
        output full_o, empty_o
    );

endinterface

// File: rtl/cv32e40p_load_desc_fifo.sv
// In-order queue of outstanding load/store descriptors.
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : enqueue push_desc_i (dropped when full without a pop)
//   pop_i         : dequeue head (ignored when empty)
//   full_o/empty_o: combinational status from count_o
//   count_o       : number of valid entries
//   head_o        : head entry
//   next_split_o  : split flag of entry head+1 (meaningful when count_o >= 2)
module cv32e40p_load_desc_fifo
    import cv32e40p_load_resp_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  load_desc_t               push_desc_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output load_desc_t               head_o,
    output logic                     next_split_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    load_desc_t            mem_q [DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q, nxt_ptr;
    logic [CntW-1:0]       count_q;
    logic                  push_acc, pop_acc;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // When full, a simultaneous pop frees the slot being written.
    assign push_acc = push_i && (!full_o || pop_i);
    assign pop_acc  = pop_i && !empty_o;

    assign nxt_ptr      = rd_ptr_q + PtrW'(1);
    assign head_o       = mem_q[rd_ptr_q];
    assign next_split_o = mem_q[nxt_ptr].split;

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_desc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_acc) begin
                rd_ptr_q <= nxt_ptr;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_o && !pop_i))
                else $error("load descriptor queue overflow, entry dropped");
        end
    end

endmodule

// File: rtl/cv32e40p_load_resp_unit.sv
// Load-response stage between the OBI response channel and EX.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request-descriptor push, queue status and bus response (slave modport)
//   rvalid_o   : one-cycle pulse per completed access
//   rdata_o    : aligned and extended load data (held between completions)
//   waddr_o    : destination register of the completed access
//   we_o       : write-back enable (descriptor we and no bus error)
//   err_o      : access ended with a bus error
//   spurious_o : one-cycle pulse when a response arrives with nothing outstanding
module cv32e40p_load_resp_unit
    import cv32e40p_load_resp_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    cv32e40p_load_resp_unit_if.slave    bus,
    output logic                        rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic [5:0]                  waddr_o,
    output logic                        we_o,
    output logic                        err_o,
    output logic                        spurious_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    load_desc_t        push_desc, head;
    logic              full, empty, next_split, pop;
    logic [CntW-1:0]   count;

    logic [31:0]       hold_q;
    logic              sticky_err_q;
    logic              rvalid_q, we_q, err_q, spurious_q;
    logic [31:0]       rdata_q;
    logic [5:0]        waddr_q;

    logic              next_valid, first_beat, complete, beat_err;
    logic [31:0]       shifted, merged;
    logic [5:0]        merge_shamt;

    assign push_desc = '{
        size:     bus.push_type_i,
        sign_ext: bus.push_sign_ext_i,
        offset:   bus.push_offset_i,
        split:    bus.push_split_i,
        we:       bus.push_we_i,
        waddr:    bus.push_waddr_i
    };

    assign pop = bus.data_rvalid_i && !empty;

    cv32e40p_load_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (bus.push_i),
        .push_desc_i  (push_desc),
        .pop_i        (pop),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .head_o       (head),
        .next_split_o (next_split)
    );

    assign bus.full_o  = full;
    assign bus.empty_o = empty;

    // If the second beat's descriptor is not queued yet, infer a pair from the
    // head's own size/offset crossing the word boundary.
    assign next_valid = (count >= CntW'(2));
    assign first_beat = !head.split &&
                        (next_valid ? next_split : crosses_word(head.size, head.offset));

    // Second beat contributes the upper bytes; offset 0 gives a shift of 32,
    // which yields zero.
    assign merge_shamt = 6'd32 - {1'b0, head.offset, 3'b000};

    always_comb begin
        shifted  = bus.data_rdata_i >> {head.offset, 3'b000};
        merged   = shifted;
        beat_err = bus.data_err_i;
        if (head.split) begin
            merged   = hold_q | (bus.data_rdata_i << merge_shamt);
            beat_err = sticky_err_q | bus.data_err_i;
        end
    end

    assign complete = pop && !first_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            sticky_err_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            rvalid_q   <= complete;
            spurious_q <= bus.data_rvalid_i && empty;
            if (pop && first_beat) begin
                hold_q       <= shifted;
                sticky_err_q <= bus.data_err_i;
            end
            if (complete) begin
                rdata_q <= extend_load(merged, head.size, head.sign_ext);
                waddr_q <= head.waddr;
                we_q    <= head.we & ~beat_err;
                err_q   <= beat_err;
            end
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign waddr_o    = waddr_q;
    assign we_o       = we_q;
    assign err_o      = err_q;
    assign spurious_o = spurious_q;

endmodule
